// File: rtl/hazard_pkg.sv
// -----------------------------------------------------------------------------
// hazard_pkg
// Shared definitions for the MIPS pipeline hazard controller:
//   - state_t      : sequencing FSM encoding (RUN / FLUSH / MEM_WAIT)
//   - REG_ZERO     : architectural register 0 (hard-wired zero, never a hazard)
//   - DEF_*        : default values for the controller parameters
// -----------------------------------------------------------------------------
package hazard_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        FLUSH    = 2'd1,
        MEM_WAIT = 2'd2
    } state_t;

    localparam int REG_ZERO         = 0;
    localparam int DEF_FLUSH_CYCLES = 1;
    localparam int DEF_MEM_TIMEOUT  = 64;

endpackage

// File: rtl/hazard_detect.sv
// -----------------------------------------------------------------------------
// hazard_detect
// Purely combinational hazard classification for the current cycle.
//
// Ports:
//   id_rs, id_rt, id_uses_rt : source operands of the instruction in ID
//   ex_mem_read, ex_rt       : load in EX and its destination register
//   branch_taken, jump       : ID-resolved control transfer
//   dmem_req, dmem_ready     : MEM-stage data-memory handshake
//   lu                       : load-use hazard (one bubble needed)
//   redir                    : fetch redirect (IF/ID holds a wrong-path instr)
//   freeze                   : data memory still busy, whole pipe must hold
// -----------------------------------------------------------------------------
module hazard_detect
    import hazard_pkg::*;
#(
    parameter int REG_ADDR_W = 5
) (
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0] id_rt,
    input  logic                  id_uses_rt,
    input  logic                  ex_mem_read,
    input  logic [REG_ADDR_W-1:0] ex_rt,
    input  logic                  branch_taken,
    input  logic                  jump,
    input  logic                  dmem_req,
    input  logic                  dmem_ready,
    output logic                  lu,
    output logic                  redir,
    output logic                  freeze
);

    localparam logic [REG_ADDR_W-1:0] ZERO_REG = REG_ADDR_W'(REG_ZERO);

    logic rs_match;
    logic rt_match;

    assign rs_match = (ex_rt == id_rs);
    // rt only matters when the ID instruction actually sources it (not for
    // I-type destinations), otherwise we would stall needlessly.
    assign rt_match = id_uses_rt & (ex_rt == id_rt);

    // Loads into $zero produce nothing to forward, so they never stall.
    assign lu     = ex_mem_read & (ex_rt != ZERO_REG) & (rs_match | rt_match);
    assign redir  = branch_taken | jump;
    // A ready without a request is meaningless and must not release anything.
    assign freeze = dmem_req & ~dmem_ready;

endmodule

// File: rtl/hazard_controller.sv
// -----------------------------------------------------------------------------
// hazard_controller
// Pipeline sequencing controller for the 5-stage MIPS core. Every cycle it
// chooses between advance, load-use stall, redirect/flush and memory freeze
// (priority freeze > load-use > redirect > normal). Outputs are Mealy: the
// decision affects the pipeline in the same cycle it is detected.
//
// Ports:
//   clk, rst              : clock (rising edge), asynchronous active-low reset
//   id_rs/id_rt/id_uses_rt: ID-stage source operands
//   ex_mem_read/ex_rt     : load in EX and its destination
//   branch_taken/jump     : ID-resolved redirect
//   dmem_req/dmem_ready   : data-memory handshake from MEM
//   pc_write              : PC load enable
//   ifid_write/ifid_flush : IF/ID load enable / load a NOP
//   ctrl_flush            : zero the ID control bundle (bubble into EX)
//   pipe_freeze           : hold ID/EX, EX/MEM and MEM/WB
//   mem_timeout           : sticky, registered memory-wait error
//
// Optional build macro HAZARD_PERF_CNT_EN adds 32-bit wrapping counters:
//   perf_stall (load-use cycles), perf_flush (ifid_flush cycles),
//   perf_freeze (freeze cycles).
// -----------------------------------------------------------------------------
module hazard_controller
    import hazard_pkg::*;
#(
    parameter int REG_ADDR_W   = 5,
    parameter int FLUSH_CYCLES = DEF_FLUSH_CYCLES,
    parameter int MEM_TIMEOUT  = DEF_MEM_TIMEOUT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0] id_rt,
    input  logic                  id_uses_rt,
    input  logic                  ex_mem_read,
    input  logic [REG_ADDR_W-1:0] ex_rt,
    input  logic                  branch_taken,
    input  logic                  jump,
    input  logic                  dmem_req,
    input  logic                  dmem_ready,
    output logic                  pc_write,
    output logic                  ifid_write,
    output logic                  ifid_flush,
    output logic                  ctrl_flush,
    output logic                  pipe_freeze,
    output logic                  mem_timeout
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [31:0]           perf_stall,
    output logic [31:0]           perf_flush,
    output logic [31:0]           perf_freeze
`endif
);

    // FLUSH_CYCLES is at most 4, so the residual count never exceeds 3.
    localparam int FC_W = 3;
    localparam int WC_W = $clog2(MEM_TIMEOUT + 1);

    localparam logic [FC_W-1:0] FLUSH_RELOAD = FC_W'(FLUSH_CYCLES - 1);
    localparam logic [WC_W-1:0] WAIT_LIMIT   = WC_W'(MEM_TIMEOUT);

    logic lu;
    logic redir;
    logic freeze;

    state_t          state, state_nxt;
    logic [FC_W-1:0] flush_cnt, flush_cnt_nxt;
    logic [WC_W-1:0] wait_cnt, wait_cnt_nxt;
    logic            timeout_nxt;

    // Wait counter stops at the timeout value instead of wrapping.
    function automatic logic [WC_W-1:0] sat_inc(input logic [WC_W-1:0] v);
        if (v >= WAIT_LIMIT)
            return v;
        else
            return v + WC_W'(1);
    endfunction

    hazard_detect #(
        .REG_ADDR_W (REG_ADDR_W)
    ) u_detect (
        .id_rs        (id_rs),
        .id_rt        (id_rt),
        .id_uses_rt   (id_uses_rt),
        .ex_mem_read  (ex_mem_read),
        .ex_rt        (ex_rt),
        .branch_taken (branch_taken),
        .jump         (jump),
        .dmem_req     (dmem_req),
        .dmem_ready   (dmem_ready),
        .lu           (lu),
        .redir        (redir),
        .freeze       (freeze)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= RUN;
            flush_cnt   <= '0;
            wait_cnt    <= '0;
            mem_timeout <= 1'b0;
        end else begin
            state       <= state_nxt;
            flush_cnt   <= flush_cnt_nxt;
            wait_cnt    <= wait_cnt_nxt;
            mem_timeout <= timeout_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        flush_cnt_nxt = flush_cnt;
        wait_cnt_nxt  = wait_cnt;
        timeout_nxt   = mem_timeout;
        pc_write      = 1'b1;
        ifid_write    = 1'b1;
        ifid_flush    = 1'b0;
        ctrl_flush    = 1'b0;
        pipe_freeze   = 1'b0;

        if (freeze) begin
            pipe_freeze = 1'b1;
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            case (state)
                RUN: begin
                    state_nxt    = MEM_WAIT;
                    wait_cnt_nxt = WC_W'(1);
                end
                MEM_WAIT: begin
                    wait_cnt_nxt = sat_inc(wait_cnt);
                    if (wait_cnt_nxt >= WAIT_LIMIT)
                        timeout_nxt = 1'b1;
                end
                FLUSH: begin
                    // Frozen flush window: residual count is held.
                end
                default: state_nxt = RUN;
            endcase
        end else if (state == FLUSH) begin
            // ID holds only bubbles here, so lu/redir are meaningless.
            ifid_flush = 1'b1;
            if (flush_cnt <= FC_W'(1)) begin
                state_nxt     = RUN;
                flush_cnt_nxt = '0;
            end else begin
                flush_cnt_nxt = flush_cnt - FC_W'(1);
            end
        end else begin
            // RUN, or the MEM_WAIT release cycle: both evaluate hazards normally.
            state_nxt    = RUN;
            wait_cnt_nxt = '0;
            if (lu) begin
                pc_write   = 1'b0;
                ifid_write = 1'b0;
                ctrl_flush = 1'b1;
            end else if (redir) begin
                ifid_flush = 1'b1;
                if (FLUSH_CYCLES > 1) begin
                    state_nxt     = FLUSH;
                    flush_cnt_nxt = FLUSH_RELOAD;
                end
            end
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_stall  <= '0;
            perf_flush  <= '0;
            perf_freeze <= '0;
        end else begin
            if (ctrl_flush)
                perf_stall <= perf_stall + 32'd1;
            if (ifid_flush)
                perf_flush <= perf_flush + 32'd1;
            if (pipe_freeze)
                perf_freeze <= perf_freeze + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_hazard_controller.sv
// -----------------------------------------------------------------------------
// tb_hazard_controller
// Directed bench for hazard_controller. Two instances share every input:
//   dut_a : FLUSH_CYCLES=3, MEM_TIMEOUT=64
//   dut_b : FLUSH_CYCLES=1, MEM_TIMEOUT=4
// Output vectors are packed as
//   {pc_write, ifid_write, ifid_flush, ctrl_flush, pipe_freeze, mem_timeout}.
// -----------------------------------------------------------------------------
module tb_hazard_controller;

    localparam logic [5:0] NORMAL = 6'b110000;
    localparam logic [5:0] STALL  = 6'b000100;
    localparam logic [5:0] REDIR  = 6'b111000;
    localparam logic [5:0] FRZ    = 6'b000010;
    localparam logic [5:0] TO_BIT = 6'b000001;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] id_rs, id_rt, ex_rt;
    logic       id_uses_rt, ex_mem_read, branch_taken, jump, dmem_req, dmem_ready;

    logic pc_write_a, ifid_write_a, ifid_flush_a, ctrl_flush_a, pipe_freeze_a, mem_timeout_a;
    logic pc_write_b, ifid_write_b, ifid_flush_b, ctrl_flush_b, pipe_freeze_b, mem_timeout_b;
    logic [5:0] va, vb;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    hazard_controller #(.REG_ADDR_W(5), .FLUSH_CYCLES(3), .MEM_TIMEOUT(64)) dut_a (
        .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .ex_mem_read(ex_mem_read), .ex_rt(ex_rt), .branch_taken(branch_taken), .jump(jump),
        .dmem_req(dmem_req), .dmem_ready(dmem_ready),
        .pc_write(pc_write_a), .ifid_write(ifid_write_a), .ifid_flush(ifid_flush_a),
        .ctrl_flush(ctrl_flush_a), .pipe_freeze(pipe_freeze_a), .mem_timeout(mem_timeout_a)
    );

    hazard_controller #(.REG_ADDR_W(5), .FLUSH_CYCLES(1), .MEM_TIMEOUT(4)) dut_b (
        .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .ex_mem_read(ex_mem_read), .ex_rt(ex_rt), .branch_taken(branch_taken), .jump(jump),
        .dmem_req(dmem_req), .dmem_ready(dmem_ready),
        .pc_write(pc_write_b), .ifid_write(ifid_write_b), .ifid_flush(ifid_flush_b),
        .ctrl_flush(ctrl_flush_b), .pipe_freeze(pipe_freeze_b), .mem_timeout(mem_timeout_b)
    );

    assign va = {pc_write_a, ifid_write_a, ifid_flush_a, ctrl_flush_a, pipe_freeze_a, mem_timeout_a};
    assign vb = {pc_write_b, ifid_write_b, ifid_flush_b, ctrl_flush_b, pipe_freeze_b, mem_timeout_b};

    task automatic check_eq(input string tag, input logic [5:0] obs, input logic [5:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic idle();
        id_rs = 5'd0; id_rt = 5'd0; ex_rt = 5'd0; id_uses_rt = 1'b0;
        ex_mem_read = 1'b0; branch_taken = 1'b0; jump = 1'b0;
        dmem_req = 1'b0; dmem_ready = 1'b0;
    endtask

    // Advance one clock and settle just after the edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        idle();
        rst = 1'b0;
        #12;
        check_eq("reset_a", va, NORMAL);
        check_eq("reset_b", vb, NORMAL);
        @(negedge clk);
        rst = 1'b1;
        cyc();

        // Load-use on rs: one bubble, then the load has left EX.
        ex_mem_read = 1'b1; ex_rt = 5'd8; id_rs = 5'd8;
        #1 check_eq("lu_rs_a", va, STALL);
        check_eq("lu_rs_b", vb, STALL);
        cyc();
        ex_mem_read = 1'b0;
        #1 check_eq("lu_after", va, NORMAL);
        cyc();

        // Register 0 never stalls; rt only counts when it is a source.
        ex_mem_read = 1'b1; ex_rt = 5'd0; id_rs = 5'd0;
        #1 check_eq("lu_r0", va, NORMAL);
        id_rs = 5'd3; ex_rt = 5'd5; id_rt = 5'd5; id_uses_rt = 1'b0;
        #1 check_eq("lu_rt_unused", va, NORMAL);
        id_uses_rt = 1'b1;
        #1 check_eq("lu_rt_used", va, STALL);
        idle();
        #1 check_eq("idle", va, NORMAL);
        cyc();

        // Redirect: a flushes 3 cycles, b flushes 1; lu ignored inside FLUSH.
        branch_taken = 1'b1;
        #1 check_eq("redir_a0", va, REDIR);
        check_eq("redir_b0", vb, REDIR);
        cyc();
        branch_taken = 1'b0;
        ex_mem_read = 1'b1; ex_rt = 5'd9; id_rs = 5'd9;
        #1 check_eq("redir_a1_lu_ignored", va, REDIR);
        check_eq("redir_b1_lu", vb, STALL);
        cyc();
        idle();
        #1 check_eq("redir_a2", va, REDIR);
        check_eq("redir_b2", vb, NORMAL);
        cyc();
        check_eq("redir_a3", va, NORMAL);
        cyc();

        // Jump behaves as a redirect too.
        jump = 1'b1;
        #1 check_eq("jump_b", vb, REDIR);
        cyc();
        idle();
        cyc(); cyc();
        check_eq("jump_a_done", va, NORMAL);

        // Priority: load-use beats branch.
        ex_mem_read = 1'b1; ex_rt = 5'd4; id_rs = 5'd4; branch_taken = 1'b1;
        #1 check_eq("prio_a", va, STALL);
        check_eq("prio_b", vb, STALL);
        cyc();
        idle();
        #1 check_eq("prio_after", va, NORMAL);
        cyc();

        // Ready without request is ignored.
        dmem_ready = 1'b1;
        #1 check_eq("ready_noreq", va, NORMAL);
        cyc();
        idle();

        // Freeze during FLUSH holds the residual count.
        branch_taken = 1'b1;
        #1 check_eq("ffl_a0", va, REDIR);
        cyc();
        branch_taken = 1'b0; dmem_req = 1'b1;
        #1 check_eq("ffl_a_frz", va, FRZ);
        check_eq("ffl_b_frz", vb, FRZ);
        cyc();
        dmem_req = 1'b0;
        #1 check_eq("ffl_a1", va, REDIR);
        check_eq("ffl_b_rel", vb, NORMAL);
        cyc();
        check_eq("ffl_a2", va, REDIR);
        cyc();
        check_eq("ffl_a3", va, NORMAL);
        cyc();

        // Memory wait: 5 frozen cycles, released in the 6th.
        dmem_req = 1'b1; dmem_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1 check_eq($sformatf("mw_a%0d", i), va, FRZ);
            check_eq($sformatf("mw_b%0d", i), vb, (i >= 4) ? (FRZ | TO_BIT) : FRZ);
            cyc();
        end
        dmem_ready = 1'b1;
        #1 check_eq("mw_rel_a", va, NORMAL);
        check_eq("mw_rel_b", vb, NORMAL | TO_BIT);
        cyc();
        idle();
        #1 check_eq("mw_sticky_b", vb, NORMAL | TO_BIT);
        check_eq("mw_post_a", va, NORMAL);

        // Reset clears the sticky timeout.
        rst = 1'b0;
        #1 check_eq("rst_clear_b", vb, NORMAL);
        cyc();
        rst = 1'b1;
        cyc();

        // Timeout then reset mid-wait.
        dmem_req = 1'b1;
        for (int i = 0; i < 6; i++) begin
            #1 check_eq($sformatf("to_b%0d", i), vb, (i >= 4) ? (FRZ | TO_BIT) : FRZ);
            check_eq($sformatf("to_a%0d", i), va, FRZ);
            cyc();
        end
        rst = 1'b0;
        dmem_req = 1'b0;
        #1 check_eq("rst_wait_a", va, NORMAL);
        check_eq("rst_wait_b", vb, NORMAL);
        cyc();
        rst = 1'b1;
        cyc();
        check_eq("rst_wait_post_b", vb, NORMAL);

        // Wait counter restarted from zero: no timeout within 4 cycles.
        dmem_req = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1 check_eq($sformatf("rw_b%0d", i), vb, FRZ);
            cyc();
        end
        idle();
        cyc();

        // Reset mid-flush returns to RUN at once.
        branch_taken = 1'b1;
        cyc();
        branch_taken = 1'b0;
        #1 check_eq("rfl_in_flush", va, REDIR);
        rst = 1'b0;
        #1 check_eq("rfl_rst", va, NORMAL);
        cyc();
        rst = 1'b1;
        cyc();
        check_eq("rfl_post", va, NORMAL);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
